// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, baud table and divisor helper.
// Constants only; no latency, no backpressure.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned DIV_W      = 20;

    localparam int unsigned BAUD_RATE [8] = '{
        300, 1200, 2400, 4800, 9600, 19200, 57600, 115200
    };

    // Majority-vote sample points within a 16-tick bit
    localparam logic [3:0] TICK_S0  = 4'd7;
    localparam logic [3:0] TICK_S1  = 4'd8;
    localparam logic [3:0] TICK_DEC = 4'd9;

    localparam logic [3:0] LAST_DATA_BIT = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    function automatic int unsigned baud_div(input int unsigned clk_freq, input logic [2:0] sel);
        return clk_freq / (BAUD_RATE[sel] * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle o_tick every i_div clocks after i_clr.
// Tick first fires i_div cycles after the clear cycle; no backpressure.
module uart_baud_tick #(
    parameter int unsigned DIV_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = (r_cnt == r_div - DIV_W'(1));

    // Divisor is captured on clear so a frame keeps its rate to the end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_div <= i_div;
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    assign o_tick = w_tick;

endmodule

// File: rtl/uart_rx_core.sv
// 16x oversampled UART receiver; byte/error strobe 1 cycle after stop-bit mid-point vote.
// No backpressure: Rx_Valid/Frame_Err are single-cycle strobes that must be taken when seen.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Rx,
    input  logic [2:0] BR_Select,
    output logic [7:0] Rx_Data,
    output logic       Rx_Valid,
    output logic       Frame_Err,
    output logic       Busy
);

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

    logic             r_rx_meta;
    logic             r_rx_s;
    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [3:0]       r_tcnt;
    logic [3:0]       w_tcnt_nxt;
    logic [3:0]       r_bit;
    logic [3:0]       w_bit_nxt;
    logic             r_s0;
    logic             r_s1;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic [7:0]       r_data;
    logic [7:0]       w_data_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_ferr;
    logic             w_ferr_nxt;
    logic             w_clr;
    logic             w_tick;
    logic             w_maj;
    logic             w_dec;
    logic             w_end;
    logic [DIV_W-1:0] w_div_tab [8];
    logic [DIV_W-1:0] w_div;

    for (genvar i = 0; i < 8; i++) begin : g_div
        assign w_div_tab[i] = DIV_W'(baud_div(CLK_FREQ, 3'(i)));
    end
    assign w_div = w_div_tab[BR_Select];

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_div  (w_div),
        .o_tick (w_tick)
    );

    assign w_maj = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
    assign w_dec = w_tick && (r_tcnt == TICK_DEC);
    assign w_end = w_tick && (r_tcnt == TICK_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_tcnt_nxt  = w_tick ? r_tcnt + 4'd1 : r_tcnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_rx_s) begin
                    w_clr       = 1'b1;
                    w_tcnt_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_dec && w_maj) begin
                    w_state_nxt = IDLE;
                end else if (w_end) begin
                    w_bit_nxt   = 4'd1;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_dec) begin
                    w_shift_nxt = {w_maj, r_shift[7:1]};
                end
                if (w_end) begin
                    if (r_bit == LAST_DATA_BIT) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_nxt = r_bit + 4'd1;
                    end
                end
            end
            // Leave at the stop mid-point so a back-to-back start edge is not missed
            STOP: begin
                if (w_dec) begin
                    if (w_maj) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (r_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_state   <= IDLE;
            r_tcnt    <= '0;
            r_bit     <= '0;
            r_s0      <= 1'b1;
            r_s1      <= 1'b1;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_rx_meta <= Rx;
            r_rx_s    <= r_rx_meta;
            r_state   <= w_state_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_ferr    <= w_ferr_nxt;
            if (w_tick && r_tcnt == TICK_S0) begin
                r_s0 <= r_rx_s;
            end
            if (w_tick && r_tcnt == TICK_S1) begin
                r_s1 <= r_rx_s;
            end
        end
    end

    assign Rx_Data   = r_data;
    assign Rx_Valid  = r_valid;
    assign Frame_Err = r_ferr;
    assign Busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed + randomized bench for uart_rx_core against a frame-level timing/data model.
module tb_uart_rx_core;

    // Reduced clock keeps the 9600-baud frames short enough to simulate quickly
    localparam int unsigned CLK_FREQ = 16_000_000;
    localparam int unsigned BAUD [8] = '{300, 1200, 2400, 4800, 9600, 19200, 57600, 115200};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Rx = 1'b1;
    logic [2:0] BR_Select = 3'd7;
    logic [7:0] Rx_Data;
    logic       Rx_Valid;
    logic       Frame_Err;
    logic       Busy;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int last_good = 0;
    int prev_dat = 0;

    typedef struct {
        int kind;   // 0 = byte received, 1 = framing error
        int dat;
        int cyc;
        int busy;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    ev_t mon_e;

    uart_rx_core #(
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Rx        (Rx),
        .BR_Select (BR_Select),
        .Rx_Data   (Rx_Data),
        .Rx_Valid  (Rx_Valid),
        .Frame_Err (Frame_Err),
        .Busy      (Busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int div_of(input int sel);
        return CLK_FREQ / (BAUD[sel] * 16);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe recorder plus always-on output invariants
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_dat = 0;
        end else begin
            if (Rx_Valid || Frame_Err) begin
                mon_e.kind = Rx_Valid ? 0 : 1;
                mon_e.dat  = int'(Rx_Data);
                mon_e.cyc  = cyc;
                mon_e.busy = int'(Busy);
                obs_q.push_back(mon_e);
                chk("strobe_exclusive", {31'b0, Rx_Valid & Frame_Err}, 32'd0);
            end
            if (int'(Rx_Data) != prev_dat) begin
                chk("data_change_needs_valid", {31'b0, Rx_Valid}, 32'd1);
                prev_dat = int'(Rx_Data);
            end
        end
    end

    task automatic hold(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic at_cycle(input int n);
        do @(negedge clk); while (cyc < n);
        if (cyc != n) begin
            miscompares++;
            $error("FAIL at_cycle: reached cycle %0d required %0d", cyc, n);
        end
    endtask

    // Rx is driven just after a rising edge in cycle p; the synchroniser puts c0 at p+2
    task automatic expect_frame(input int p, input int sel, input int kind, input int dat);
        ev_t e;
        int c0;
        c0 = p + 2;
        e.kind = kind;
        e.dat  = dat;
        e.cyc  = c0 + 154 * div_of(sel) + 1;
        e.busy = (kind == 0) ? 0 : 1;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] dat, input logic stop, input int sel,
                              input int chg_bit, input int chg_sel, input int rst_bit,
                              input int extra_low, input bit align,
                              output int p, output int h);
        int d;
        logic [9:0] bits;
        d    = div_of(sel);
        bits = {stop, dat, 1'b0};
        if (align) begin
            @(posedge clk);
            #1;
        end
        BR_Select = 3'(sel);
        p = cyc;
        h = cyc;
        for (int b = 0; b < 10; b++) begin
            if (b == chg_bit) BR_Select = 3'(chg_sel);
            Rx = bits[b];
            if (b == rst_bit) begin
                hold(8 * d);
                #2;
                rst_n = 1'b0;
                Rx    = 1'b1;
                #1;
                chk("rst_mid_data",  {24'b0, Rx_Data}, 32'h00);
                chk("rst_mid_valid", {31'b0, Rx_Valid}, 32'd0);
                chk("rst_mid_ferr",  {31'b0, Frame_Err}, 32'd0);
                chk("rst_mid_busy",  {31'b0, Busy}, 32'd0);
                hold(3);
                rst_n = 1'b1;
                h = cyc;
                return;
            end
            hold(16 * d);
        end
        if (!stop) hold(extra_low);
        Rx = 1'b1;
        h  = cyc;
    endtask

    task automatic compare_events(input string tag);
        int n;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
            chk({tag, "_data"}, obs_q[i].dat,  exp_q[i].dat);
            chk({tag, "_cycle"}, obs_q[i].cyc, exp_q[i].cyc);
            chk({tag, "_busy"}, obs_q[i].busy, exp_q[i].busy);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // After an error, Busy falls one cycle after the synchronised line is seen high
    task automatic busy_fall(input string tag, input int h);
        at_cycle(h + 2);
        chk({tag, "_busy_hi"}, {31'b0, Busy}, 32'd1);
        at_cycle(h + 3);
        chk({tag, "_busy_lo"}, {31'b0, Busy}, 32'd0);
    endtask

    initial begin
        int p, h, p2, d, sel, gap;
        logic [7:0] rdat;
        logic       rstop;

        #23;
        chk("reset_data",  {24'b0, Rx_Data}, 32'h00);
        chk("reset_valid", {31'b0, Rx_Valid}, 32'd0);
        chk("reset_ferr",  {31'b0, Frame_Err}, 32'd0);
        chk("reset_busy",  {31'b0, Busy}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(10);
        @(negedge clk);
        chk("post_reset_busy", {31'b0, Busy}, 32'd0);

        // Good frame at the fastest rate
        send_frame(8'hA5, 1'b1, 7, -1, 0, -1, 0, 1'b1, p, h);
        expect_frame(p, 7, 0, 8'hA5);
        last_good = 8'hA5;
        compare_events("good_a5");
        chk("good_a5_hold", {24'b0, Rx_Data}, 32'hA5);

        // False start: a glitch shorter than the start-bit mid-point
        d = div_of(7);
        @(posedge clk);
        #1;
        BR_Select = 3'd7;
        p = cyc;
        Rx = 1'b0;
        hold(4 * d);
        Rx = 1'b1;
        at_cycle(p + 2 + 10 * d);
        chk("false_start_busy_hi", {31'b0, Busy}, 32'd1);
        at_cycle(p + 3 + 10 * d);
        chk("false_start_busy_lo", {31'b0, Busy}, 32'd0);
        hold(160 * d);
        compare_events("false_start");
        chk("false_start_data", {24'b0, Rx_Data}, 32'hA5);

        // Framing error keeps the previous byte, then a normal frame follows
        send_frame(8'h3C, 1'b0, 7, -1, 0, -1, 0, 1'b1, p, h);
        expect_frame(p, 7, 1, last_good);
        busy_fall("ferr", h);
        compare_events("ferr_3c");
        chk("ferr_data_kept", {24'b0, Rx_Data}, 32'hA5);
        send_frame(8'h55, 1'b1, 7, -1, 0, -1, 0, 1'b1, p, h);
        expect_frame(p, 7, 0, 8'h55);
        last_good = 8'h55;
        compare_events("after_ferr_55");

        // Break: line low for several frame times gives exactly one error
        send_frame(8'h00, 1'b0, 7, -1, 0, -1, 4000, 1'b1, p, h);
        expect_frame(p, 7, 1, last_good);
        busy_fall("break", h);
        hold(20);
        compare_events("break");

        // Back-to-back frames at 9600 with no idle gap
        send_frame(8'h00, 1'b1, 4, -1, 0, -1, 0, 1'b1, p, h);
        send_frame(8'hFF, 1'b1, 4, -1, 0, -1, 0, 1'b0, p2, h);
        chk("b2b_no_gap", p2, p + 160 * div_of(4));
        expect_frame(p, 4, 0, 8'h00);
        expect_frame(p2, 4, 0, 8'hFF);
        last_good = 8'hFF;
        compare_events("b2b");

        // Baud select changes during bit 4 must not disturb the frame in flight
        send_frame(8'h81, 1'b1, 7, 4, 0, -1, 0, 1'b1, p, h);
        expect_frame(p, 7, 0, 8'h81);
        last_good = 8'h81;
        compare_events("baud_change");

        // Asynchronous reset during bit 5, then a clean frame
        send_frame(8'hC3, 1'b1, 7, -1, 0, 5, 0, 1'b1, p, h);
        last_good = 0;
        hold(20);
        @(negedge clk);
        chk("rst_after_busy", {31'b0, Busy}, 32'd0);
        chk("rst_after_data", {24'b0, Rx_Data}, 32'h00);
        compare_events("rst_abort");
        send_frame(8'h42, 1'b1, 7, -1, 0, -1, 0, 1'b1, p, h);
        expect_frame(p, 7, 0, 8'h42);
        last_good = 8'h42;
        compare_events("after_rst_42");

        // Randomized frames at the two fastest rates, some with a bad stop bit
        for (int k = 0; k < 6; k++) begin
            rdat  = 8'($urandom);
            sel   = int'($urandom_range(6, 7));
            rstop = ($urandom_range(0, 3) != 0);
            gap   = int'($urandom_range(0, 20));
            send_frame(rdat, rstop, sel, -1, 0, -1, 0, 1'b1, p, h);
            if (rstop) begin
                expect_frame(p, sel, 0, int'(rdat));
                last_good = int'(rdat);
            end else begin
                expect_frame(p, sel, 1, last_good);
            end
            hold(3 + gap);
            compare_events("rand");
            chk("rand_data_held", {24'b0, Rx_Data}, 32'(last_good));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
